reg_read: RTL and testbench

//   Register-read stage: holds the 8x32 register file and accepts fetched instructions.

---
 rtl/reg_read_pkg.sv | 60 ++++++
 rtl/reg_read_if.sv | 21 ++
 rtl/reg_read_regfile.sv | 33 +++
 rtl/reg_read.sv | 70 +++++++
 tb/tb_reg_read.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/reg_read_pkg.sv
// Shared CPU definitions: widths, opcode encodings, instruction fields and the
// packed stage-register layouts exchanged between register-read and exec.
package cpu_pkg;

  localparam int D_BITS       = 32;
  localparam int INSTR_BITS   = 16;
  localparam int NREGS        = 8;
  localparam int REG_IDX_BITS = 3;
  localparam int RR_BITS      = INSTR_BITS + 2 * D_BITS;
  localparam int ER_BITS      = D_BITS + REG_IDX_BITS + 1;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 9;
  localparam int DST_MSB  = 8;
  localparam int DST_LSB  = 6;
  localparam int SRC1_MSB = 5;
  localparam int SRC1_LSB = 3;
  localparam int SRC2_MSB = 2;
  localparam int SRC2_LSB = 0;

  typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;
  typedef logic [REG_IDX_BITS-1:0]  reg_idx_t;

  localparam opcode_t OP_NOP     = 7'h00;
  localparam opcode_t OP_ADD     = 7'h01;
  localparam opcode_t OP_SUB     = 7'h02;
  localparam opcode_t OP_AND     = 7'h03;
  localparam opcode_t OP_OR      = 7'h04;
  localparam opcode_t OP_XOR     = 7'h05;
  localparam opcode_t OP_SHIFTR  = 7'h06;
  localparam opcode_t OP_SHIFTRA = 7'h07;
  localparam opcode_t OP_SHIFTL  = 7'h08;
  localparam opcode_t OP_HALT    = 7'h7F;

  localparam logic [INSTR_BITS-1:0] NOP_INSTR  = {OP_NOP, 9'b0};
  localparam logic [INSTR_BITS-1:0] HALT_INSTR = {OP_HALT, 9'b0};

  typedef struct packed {
    logic [INSTR_BITS-1:0] instr;
    logic [D_BITS-1:0]     op1;
    logic [D_BITS-1:0]     op2;
  } rr_t;

  typedef struct packed {
    logic [D_BITS-1:0] result;
    reg_idx_t          dest;
    logic              write_en;
  } er_t;

  // Shifts carry an immediate in the src2 field, so it never names a register.
  function automatic logic is_shift(input opcode_t opc);
    return (opc == OP_SHIFTR) || (opc == OP_SHIFTRA) || (opc == OP_SHIFTL);
  endfunction

  // True for opcodes that produce a register result.
  function automatic logic writes_reg(input opcode_t opc);
    return (opc != OP_NOP) && (opc != OP_HALT);
  endfunction

endpackage

// File: rtl/reg_read_if.sv
// Fetch/write-back/exec bus seen by the register-read stage.
interface reg_read_if;
  import cpu_pkg::*;

  logic                  in_valid;
  logic [INSTR_BITS-1:0] in_instr;
  logic                  in_ready;
  er_t                   wb_in;
  rr_t                   rr_out;
  logic                  halted;

  modport master (
    output in_valid, in_instr, wb_in,
    input  in_ready, rr_out, halted
  );

  modport slave (
    input  in_valid, in_instr, wb_in,
    output in_ready, rr_out, halted
  );
endinterface

// File: rtl/reg_read_regfile.sv
// 8x32 register file: two async read ports with write-before-read bypass,
// one synchronous write port, asynchronous active-low clear.
module regfile_8x32
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  reg_idx_t          ra1,
  input  reg_idx_t          ra2,
  output logic [D_BITS-1:0] rd1,
  output logic [D_BITS-1:0] rd2,
  input  logic              we,
  input  reg_idx_t          wa,
  input  logic [D_BITS-1:0] wd
);

  logic [D_BITS-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  // A same-cycle write wins over the stored entry so readers never see stale data.
  always_comb begin
    rd1 = (we && (wa == ra1)) ? wd : regs[ra1];
    rd2 = (we && (wa == ra2)) ? wd : regs[ra2];
  end

endmodule

// File: rtl/reg_read.sv
// Register-read stage: operand fetch, one-cycle RAW stall against the
// instruction in exec, HALT freeze, and the registered hand-off to exec.
module reg_read
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  reg_read_if.slave bus
);

  rr_t               rr_p0;
  logic              halted_q;
  logic [D_BITS-1:0] op1;
  logic [D_BITS-1:0] op2;
  opcode_t           in_opc;
  reg_idx_t          src1;
  reg_idx_t          src2;
  reg_idx_t          prod_dst;
  logic              prod_wr;
  logic              stall;
  logic              in_ready;
  logic              accept;

  assign in_opc   = bus.in_instr[OPC_MSB:OPC_LSB];
  assign src1     = bus.in_instr[SRC1_MSB:SRC1_LSB];
  assign src2     = bus.in_instr[SRC2_MSB:SRC2_LSB];
  assign prod_wr  = writes_reg(rr_p0.instr[OPC_MSB:OPC_LSB]);
  assign prod_dst = rr_p0.instr[DST_MSB:DST_LSB];

  regfile_8x32 u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (src1),
    .ra2   (src2),
    .rd1   (op1),
    .rd2   (op2),
    .we    (bus.wb_in.write_en),
    .wa    (bus.wb_in.dest),
    .wd    (bus.wb_in.result)
  );

  // The producer's result is only one stage away, so a single bubble lets
  // the write-back bypass deliver it on the retry.
  always_comb begin
    stall = bus.in_valid && prod_wr && writes_reg(in_opc) &&
            ((src1 == prod_dst) || (!is_shift(in_opc) && (src2 == prod_dst)));
    in_ready = rst_n && !halted_q && !stall;
    accept   = bus.in_valid && in_ready;
  end

  // Stage boundary: register-read -> exec
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_p0    <= '{instr: NOP_INSTR, op1: '0, op2: '0};
      halted_q <= 1'b0;
    end else begin
      if (accept) begin
        rr_p0 <= '{instr: bus.in_instr, op1: op1, op2: op2};
      end else begin
        rr_p0 <= '{instr: NOP_INSTR, op1: '0, op2: '0};
      end
      if (accept && (in_opc == OP_HALT)) halted_q <= 1'b1;
    end
  end

  assign bus.rr_out   = rr_p0;
  assign bus.halted   = halted_q;
  assign bus.in_ready = in_ready;

endmodule

// File: tb/tb_reg_read.sv
// Directed bench for the register-read stage: reset, bypass, RAW stall,
// shift exemption, idle bubbles and HALT freeze.
module tb_reg_read;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  reg_read_if bus ();

  reg_read dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mk(input opcode_t op, input reg_idx_t d,
                                     input reg_idx_t s1, input reg_idx_t s2);
    return {op, d, s1, s2};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [31:0] r, input reg_idx_t d, input logic we);
    bus.wb_in = '{result: r, dest: d, write_en: we};
  endtask

  initial begin
    logic [79:0] nop_rr;
    nop_rr       = {NOP_INSTR, 64'h0};
    n_pass       = 0;
    n_total      = 0;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = NOP_INSTR;
    wb(32'h0, 3'd0, 1'b0);
    #2 rst_n = 1'b0;

    // Power-on reset with a pending instruction
    bus.in_valid = 1'b1;
    bus.in_instr = mk(OP_ADD, 3'd1, 3'd2, 3'd3);
    step();
    step();
    chk("reset_rr_out", bus.rr_out, nop_rr);
    chk("reset_halted", bus.halted, 1'b0);
    chk("reset_in_ready", bus.in_ready, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;

    // Load r5 so the mid-stream reset has something to clear
    wb(32'hDEADBEEF, 3'd5, 1'b1);
    step();
    wb(32'h0, 3'd0, 1'b0);
    chk("rf_r5_loaded", dut.u_rf.regs[5], 32'hDEADBEEF);
    bus.in_valid = 1'b1;
    bus.in_instr = mk(OP_ADD, 3'd1, 3'd5, 3'd5);
    step();
    chk("add_r5_issue", bus.rr_out, {mk(OP_ADD, 3'd1, 3'd5, 3'd5), 32'hDEADBEEF, 32'hDEADBEEF});
    bus.in_instr = mk(OP_SUB, 3'd4, 3'd1, 3'd2);
    #1;
    chk("pre_reset_stall", bus.in_ready, 1'b0);

    // Mid-stream reset discards the stalled SUB and ignores write-back
    rst_n = 1'b0;
    wb(32'h77, 3'd6, 1'b1);
    #1;
    chk("midrst_rr_out", bus.rr_out, nop_rr);
    chk("midrst_halted", bus.halted, 1'b0);
    chk("midrst_in_ready", bus.in_ready, 1'b0);
    step();
    wb(32'h0, 3'd0, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) chk($sformatf("rf_clear_r%0d", i), dut.u_rf.regs[i], 32'h0);

    // Write-before-read bypass
    wb(32'h12345678, 3'd3, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_instr = mk(OP_ADD, 3'd1, 3'd3, 3'd3);
    #1;
    chk("bypass_in_ready", bus.in_ready, 1'b1);
    step();
    wb(32'h0, 3'd0, 1'b0);
    chk("bypass_rr_out", bus.rr_out, {mk(OP_ADD, 3'd1, 3'd3, 3'd3), 32'h12345678, 32'h12345678});

    // RAW stall on src1, with a write to r5 landing during the stall
    bus.in_instr = mk(OP_ADD, 3'd2, 3'd3, 3'd3);
    step();
    chk("add_r2_issue", bus.rr_out, {mk(OP_ADD, 3'd2, 3'd3, 3'd3), 32'h12345678, 32'h12345678});
    bus.in_instr = mk(OP_SUB, 3'd4, 3'd2, 3'd5);
    wb(32'h55, 3'd5, 1'b1);
    #1;
    chk("raw_stall_ready", bus.in_ready, 1'b0);
    step();
    chk("raw_bubble", bus.rr_out, nop_rr);
    wb(32'h2468ACF0, 3'd2, 1'b1);
    #1;
    chk("raw_retry_ready", bus.in_ready, 1'b1);
    step();
    wb(32'h0, 3'd0, 1'b0);
    chk("raw_sub_issue", bus.rr_out, {mk(OP_SUB, 3'd4, 3'd2, 3'd5), 32'h2468ACF0, 32'h00000055});

    // Shift whose val field aliases the producer's dest does not stall
    bus.in_instr = mk(OP_ADD, 3'd2, 3'd1, 3'd1);
    step();
    chk("add_r2_again", bus.rr_out, {mk(OP_ADD, 3'd2, 3'd1, 3'd1), 64'h0});
    bus.in_instr = mk(OP_SHIFTL, 3'd6, 3'd1, 3'd2);
    #1;
    chk("shift_no_stall", bus.in_ready, 1'b1);
    step();
    chk("shift_issue", bus.rr_out, {mk(OP_SHIFTL, 3'd6, 3'd1, 3'd2), 32'h0, 32'h2468ACF0});

    // A non-shift src2 match does stall
    bus.in_instr = mk(OP_OR, 3'd0, 3'd1, 3'd6);
    #1;
    chk("src2_stall", bus.in_ready, 1'b0);
    bus.in_valid = 1'b0;

    // Idle: three bubbles, register file untouched
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("idle_bubble%0d", i), bus.rr_out, nop_rr);
    end
    chk("idle_r3_kept", dut.u_rf.regs[3], 32'h12345678);
    chk("idle_r2_kept", dut.u_rf.regs[2], 32'h2468ACF0);

    // HALT is issued, then the stage freezes but write-back still lands
    bus.in_valid = 1'b1;
    bus.in_instr = HALT_INSTR;
    #1;
    chk("halt_accept_ready", bus.in_ready, 1'b1);
    step();
    chk("halt_issue", bus.rr_out, {HALT_INSTR, 64'h0});
    chk("halt_flag", bus.halted, 1'b1);
    bus.in_instr = mk(OP_ADD, 3'd1, 3'd7, 3'd7);
    wb(32'hA5, 3'd7, 1'b1);
    #1;
    chk("halt_in_ready", bus.in_ready, 1'b0);
    step();
    wb(32'h0, 3'd0, 1'b0);
    chk("halt_bubble0", bus.rr_out, nop_rr);
    chk("halt_wb_r7", dut.u_rf.regs[7], 32'hA5);
    step();
    chk("halt_bubble1", bus.rr_out, nop_rr);
    chk("halt_sticky", bus.halted, 1'b1);
    chk("halt_ready_stays0", bus.in_ready, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
